// File: rtl/ifetch_112.sv
// ifetch_112: MIPS fetch stage (PC, instruction memory, field split, next-PC); define IFETCH_HALT_EN to halt on 32'hFFFF_FFFF
module ifetch_112 #(
  parameter int          ADDR_W   = 10,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              branch,
  input  logic              jump,
  input  logic              zero,
  input  logic              imem_we,
  input  logic [ADDR_W-1:0] imem_waddr,
  input  logic [31:0]       imem_wdata,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic [31:0]       instr,
  output logic [5:0]        op,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd,
  output logic [4:0]        shamt,
  output logic [5:0]        funct,
  output logic [15:0]       imm16,
  output logic [25:0]       target,
  output logic [31:0]       instr_count,
  output logic              halted
);
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  logic [31:0] next_pc;
  logic        halt_now;
  logic        adv;
  assign instr    = mem[pc[ADDR_W+1:2]];
  assign pc_plus4 = pc + 32'd4;
  assign op       = instr[31:26];
  assign rs       = instr[25:21];
  assign rt       = instr[20:16];
  assign rd       = instr[15:11];
  assign shamt    = instr[10:6];
  assign funct    = instr[5:0];
  assign imm16    = instr[15:0];
  assign target   = instr[25:0];
`ifdef IFETCH_HALT_EN
  assign halt_now = instr == 32'hFFFF_FFFF;
  // halt latches on an unstalled edge that fetches the halt word, cleared only by reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) halted <= 1'b0;
    else if (!stall && halt_now) halted <= 1'b1;
`else
  assign halt_now = 1'b0;
  assign halted   = 1'b0;
`endif
  assign adv = !stall && !halted && !halt_now;
  // redirect priority: jump over taken branch over sequential
  always_comb
    next_pc = jump ? {pc_plus4[31:28], target, 2'b00} :
              (branch && zero) ? pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00} : pc_plus4;
  // PC and retired-instruction counter advance together
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc          <= RESET_PC;
      instr_count <= 32'd0;
    end else if (adv) begin
      pc          <= next_pc;
      instr_count <= instr_count + 32'd1;
    end
  // load port, not reset so contents survive rst_n
  always_ff @(posedge clk)
    if (imem_we) mem[imem_waddr] <= imem_wdata;
endmodule

// File: tb/tb_ifetch_112.sv
// tb_ifetch_112: scoreboard bench for ifetch_112 against a behavioural fetch model
module tb_ifetch_112;
  localparam int          AW  = 10;
  localparam logic [31:0] RPC = 32'h1000_0000;
  logic clk, rst_n, stall, branch, jump, zero, imem_we;
  logic [AW-1:0] imem_waddr;
  logic [31:0] imem_wdata, pc, pc_plus4, instr, instr_count;
  logic [5:0] op, funct;
  logic [4:0] rs, rt, rd, shamt;
  logic [15:0] imm16;
  logic [25:0] target;
  logic halted;
  ifetch_112 #(.ADDR_W(AW), .RESET_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch(branch), .jump(jump), .zero(zero),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .pc(pc), .pc_plus4(pc_plus4), .instr(instr), .op(op), .rs(rs), .rt(rt), .rd(rd),
    .shamt(shamt), .funct(funct), .imm16(imm16), .target(target),
    .instr_count(instr_count), .halted(halted)
  );
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] cnt;
    logic        h;
  } exp_t;
  exp_t q[$];
  logic [31:0] m_mem [0:(1<<AW)-1];
  logic [31:0] m_pc, m_cnt;
  bit m_halt;
  bit chk;
  int checks, passed;
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  task automatic cycle(input bit s, input bit b, input bit j, input bit z, input bit we,
                       input logic [AW-1:0] wa, input logic [31:0] wd, input bit r);
    logic [31:0] cur, pc4;
    int off;
    @(negedge clk);
    stall = s; branch = b; jump = j; zero = z;
    imem_we = we; imem_waddr = wa; imem_wdata = wd; rst_n = !r;
    if (r) begin
      m_pc = RPC; m_cnt = 0; m_halt = 0;
    end
    #1;
    cur = m_mem[(m_pc / 4) % (1 << AW)];
    if (chk) q.push_back('{pc: m_pc, instr: cur, cnt: m_cnt, h: m_halt});
    if (!r && !s && !m_halt) begin
`ifdef IFETCH_HALT_EN
      if (cur == 32'hFFFF_FFFF) m_halt = 1;
`endif
      if (!m_halt) begin
        pc4 = m_pc + 4;
        off = int'($signed(cur[15:0])) * 4;
        if (j) m_pc = (pc4 & 32'hF000_0000) + (cur % (1 << 26)) * 4;
        else if (b && z) m_pc = pc4 + 32'(off);
        else m_pc = pc4;
        m_cnt = m_cnt + 1;
      end
    end
    if (we) m_mem[wa] = wd;
  endtask
  task automatic run(input bit s, input bit b, input bit j, input bit z);
    cycle(s, b, j, z, 0, '0, '0, 0);
  endtask
  // monitor: compares every expectation the driver queued, away from the clock edge
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      while (q.size() > 0) begin
        e = q.pop_front();
        cmp("pc", pc, e.pc);
        cmp("pc_plus4", pc_plus4, e.pc + 32'd4);
        cmp("instr", instr, e.instr);
        cmp("fields", {op, rs, rt, rd, shamt, funct}, e.instr);
        cmp("imm16", {16'h0, imm16}, {16'h0, e.instr[15:0]});
        cmp("target", {6'h0, target}, {6'h0, e.instr[25:0]});
        cmp("instr_count", instr_count, e.cnt);
        cmp("halted", {31'h0, halted}, {31'h0, e.h});
      end
    end
  end
  initial begin
    logic [31:0] w;
    rst_n = 1; stall = 0; branch = 0; jump = 0; zero = 0;
    imem_we = 0; imem_waddr = '0; imem_wdata = '0;
    m_pc = RPC; m_cnt = 0; m_halt = 0; chk = 0;
    for (int i = 0; i < (1 << AW); i++) begin
      w = $urandom;
      if (w == 32'hFFFF_FFFF) w = 32'h0;
      case (i)
        0: w = 32'h2108_0001;
        1: w = 32'h0128_4020;
        2: w = 32'h1000_FFFE;
        3: w = 32'h8C09_0004;
        4: w = 32'h0800_0040;
        default: ;
      endcase
      cycle(0, 0, 0, 0, 1, AW'(i), w, 1);
    end
    chk = 1;
    cycle(0, 0, 0, 0, 0, '0, '0, 1);
    run(0, 0, 0, 0);
    run(0, 0, 0, 0);
    run(0, 1, 0, 1);
    run(0, 0, 0, 0);
    run(0, 1, 0, 0);
    run(0, 0, 0, 0);
    run(0, 1, 1, 1);
    run(0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, '0, '0, 1);
    run(0, 0, 0, 0);
    run(1, 0, 0, 0);
    run(1, 0, 0, 0);
    run(1, 1, 1, 1);
    run(0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, AW'(2), 32'hA5A5_5A5A, 0);
    run(0, 0, 0, 0);
    run(0, 0, 0, 0);
    cycle(0, 1, 1, 1, 0, '0, '0, 1);
    run(0, 0, 0, 0);
    for (int i = 0; i < 2000; i++) begin
      w = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
      cycle($urandom_range(0, 3) == 0, 1'($urandom), 1'($urandom_range(0, 5) == 0), 1'($urandom),
            $urandom_range(0, 7) == 0, AW'($urandom), w, $urandom_range(0, 99) == 0);
    end
    cycle(0, 0, 0, 0, 1, AW'(0), 32'h2108_0001, 1);
    cycle(0, 0, 0, 0, 1, AW'(1), 32'hFFFF_FFFF, 1);
    cycle(0, 0, 0, 0, 1, AW'(2), 32'h0000_0000, 1);
    for (int i = 0; i < 4; i++) run(0, 1, 1, 1);
    @(negedge clk);
    #5;
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
